// File: rtl/mux_sel_scheduler.sv
// mux_sel_scheduler: round-robin channel scheduler producing the 2-bit select
// for the downstream four-input mux_processor. Each grant is held for a
// programmable dwell count; a grant can be released early by its requester.
// Optional build macro: MUX_SCHED_PRIO_EN makes channel 0 urgent (it preempts
// any other grant and wins from idle). Undefined = pure round-robin.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | no grant active, VALID=0, GNT=0, SEL holds last value
// S_GRANT | grant active on SEL, cnt counts remaining dwell cycles

module mux_sel_scheduler #(
   parameter int DWELL_W = 4
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               EN,
   input  logic [3:0]         REQ,
   input  logic [DWELL_W-1:0] DWELL,
   output logic [1:0]         SEL,
   output logic [3:0]         GNT,
   output logic               VALID,
   output logic               SWITCH
);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_GRANT = 1'b1
   } state_t;

   state_t             state;
   logic [DWELL_W-1:0] cnt;
   logic [1:0]         last;

   logic [1:0]         pick;
   logic [1:0]         grant_ch;
   logic               do_grant;
   logic               go_idle;
   logic [DWELL_W-1:0] load_val;

   // First requester in the order last+1, last+2, last+3, last (mod 4).
   // Iterating from the farthest offset down lets the nearest one win.
   function automatic logic [1:0] next_ch(input logic [3:0] req, input logic [1:0] from);
      logic [1:0] ch;
      next_ch = from;
      for (int k = 4; k >= 1; k--) begin
         ch = from + 2'(k);
         if (req[ch]) next_ch = ch;
      end
   endfunction

   // Dwell of 0 behaves as 1, so the reload value saturates at 0.
   always_comb begin
      load_val = (DWELL == '0) ? '0 : DWELL - DWELL_W'(1);
   end

   // Decide whether the next edge starts a grant, drops to idle, or keeps counting.
   always_comb begin
      pick     = next_ch(REQ, last);
      grant_ch = pick;
      do_grant = 1'b0;
      go_idle  = 1'b0;
      case (state)
         S_IDLE: begin
            if (EN && (|REQ)) begin
               do_grant = 1'b1;
`ifdef MUX_SCHED_PRIO_EN
               if (REQ[0]) grant_ch = 2'd0;
`endif
            end else begin
               go_idle = 1'b1;
            end
         end
         S_GRANT: begin
            if (!EN) begin
               go_idle = 1'b1;
            end
`ifdef MUX_SCHED_PRIO_EN
            else if ((SEL != 2'd0) && REQ[0]) begin
               do_grant = 1'b1;
               grant_ch = 2'd0;
            end
`endif
            else if (!REQ[SEL] || (cnt == '0)) begin
               if (|REQ) do_grant = 1'b1;
               else      go_idle  = 1'b1;
            end
         end
         default: go_idle = 1'b1;
      endcase
   end

   // Registered FSM and outputs; SEL is only updated when a new grant starts.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state  <= S_IDLE;
         SEL    <= 2'd0;
         GNT    <= 4'b0000;
         VALID  <= 1'b0;
         SWITCH <= 1'b0;
         cnt    <= '0;
         last   <= 2'd3;
      end else if (do_grant) begin
         state  <= S_GRANT;
         SEL    <= grant_ch;
         last   <= grant_ch;
         GNT    <= 4'b0001 << grant_ch;
         VALID  <= 1'b1;
         SWITCH <= 1'b1;
         cnt    <= load_val;
      end else if (go_idle) begin
         state  <= S_IDLE;
         GNT    <= 4'b0000;
         VALID  <= 1'b0;
         SWITCH <= 1'b0;
      end else begin
         cnt    <= cnt - DWELL_W'(1);
         SWITCH <= 1'b0;
      end
   end

endmodule
